// File: rtl/posit_mul_arbiter.sv
// Two-requester round-robin issue into a shared posit scale-add/fraction-multiply
// datapath, with a two-stage (issue, result) back-pressurable pipeline.

module scale_and_mul #(
    parameter int SPEED = 0
) (
    input  logic [3:0]  scale_a,
    input  logic [3:0]  scale_b,
    input  logic [5:0]  frac_a,
    input  logic [5:0]  frac_b,
    output logic [4:0]  scale,
    output logic [11:0] frac
);
    assign scale = {scale_a[3], scale_a} + {scale_b[3], scale_b};

    generate
        if (SPEED == 0) begin : g_direct
            assign frac = {6'd0, frac_a} * {6'd0, frac_b};
        end else begin : g_shift_add
            // Explicit partial-product sum for tools with a weak multiplier
            always_comb begin
                frac = 12'd0;
                for (int i = 0; i < 6; i++) begin
                    if (frac_b[i]) frac = frac + ({6'd0, frac_a} << i);
                end
            end
        end
    endgenerate
endmodule

module posit_mul_arbiter #(
    parameter int SPEED = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0_VALID,
    output logic        REQ0_READY,
    input  logic [3:0]  REQ0_SCALE_A,
    input  logic [3:0]  REQ0_SCALE_B,
    input  logic [5:0]  REQ0_FRAC_A,
    input  logic [5:0]  REQ0_FRAC_B,
    input  logic        REQ1_VALID,
    output logic        REQ1_READY,
    input  logic [3:0]  REQ1_SCALE_A,
    input  logic [3:0]  REQ1_SCALE_B,
    input  logic [5:0]  REQ1_FRAC_A,
    input  logic [5:0]  REQ1_FRAC_B,
    output logic        RES_VALID,
    input  logic        RES_READY,
    output logic        RES_ID,
    output logic [4:0]  RES_SCALE,
    output logic [11:0] RES_FRAC,
    output logic [7:0]  DONE_CNT
);
    logic        last;
    logic        s1_valid;
    logic        s1_id;
    logic [3:0]  s1_sa;
    logic [3:0]  s1_sb;
    logic [5:0]  s1_fa;
    logic [5:0]  s1_fb;
    logic        s1_load;
    logic        s2_load;
    logic        grant0;
    logic        grant1;
    logic        acc;
    logic [4:0]  dp_scale;
    logic [11:0] dp_frac;

    assign s2_load = !RES_VALID || RES_READY;
    assign s1_load = !s1_valid || s2_load;

    // On a tie the requester that did not win last time goes next
    assign grant0 = REQ0_VALID && (!REQ1_VALID || last);
    assign grant1 = REQ1_VALID && (!REQ0_VALID || !last);

    assign REQ0_READY = grant0 && s1_load && RST_N;
    assign REQ1_READY = grant1 && s1_load && RST_N;
    assign acc        = REQ0_READY || REQ1_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last     <= 1'b1;
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_sa    <= 4'd0;
            s1_sb    <= 4'd0;
            s1_fa    <= 6'd0;
            s1_fb    <= 6'd0;
        end else begin
            if (acc) last <= REQ1_READY;
            if (s1_load) begin
                s1_valid <= acc;
                s1_id    <= REQ1_READY;
                s1_sa    <= REQ1_READY ? REQ1_SCALE_A : REQ0_SCALE_A;
                s1_sb    <= REQ1_READY ? REQ1_SCALE_B : REQ0_SCALE_B;
                s1_fa    <= REQ1_READY ? REQ1_FRAC_A  : REQ0_FRAC_A;
                s1_fb    <= REQ1_READY ? REQ1_FRAC_B  : REQ0_FRAC_B;
            end
        end
    end

    scale_and_mul #(
        .SPEED (SPEED)
    ) u_dp (
        .scale_a (s1_sa),
        .scale_b (s1_sb),
        .frac_a  (s1_fa),
        .frac_b  (s1_fb),
        .scale   (dp_scale),
        .frac    (dp_frac)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            RES_VALID <= 1'b0;
            RES_ID    <= 1'b0;
            RES_SCALE <= 5'd0;
            RES_FRAC  <= 12'd0;
            DONE_CNT  <= 8'd0;
        end else begin
            if (s2_load) begin
                RES_VALID <= s1_valid;
                RES_ID    <= s1_id;
                RES_SCALE <= dp_scale;
                RES_FRAC  <= dp_frac;
            end
            if (RES_VALID && RES_READY) DONE_CNT <= DONE_CNT + 8'd1;
        end
    end
endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed and random checks of posit_mul_arbiter against a queue-based
// in-order model of accepted operations.

module tb_posit_mul_arbiter;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ0_VALID = 1'b0;
    logic        REQ0_READY;
    logic [3:0]  REQ0_SCALE_A = '0;
    logic [3:0]  REQ0_SCALE_B = '0;
    logic [5:0]  REQ0_FRAC_A = '0;
    logic [5:0]  REQ0_FRAC_B = '0;
    logic        REQ1_VALID = 1'b0;
    logic        REQ1_READY;
    logic [3:0]  REQ1_SCALE_A = '0;
    logic [3:0]  REQ1_SCALE_B = '0;
    logic [5:0]  REQ1_FRAC_A = '0;
    logic [5:0]  REQ1_FRAC_B = '0;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic        RES_ID;
    logic [4:0]  RES_SCALE;
    logic [11:0] RES_FRAC;
    logic [7:0]  DONE_CNT;

    posit_mul_arbiter #(.SPEED(0)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .REQ0_VALID   (REQ0_VALID),
        .REQ0_READY   (REQ0_READY),
        .REQ0_SCALE_A (REQ0_SCALE_A),
        .REQ0_SCALE_B (REQ0_SCALE_B),
        .REQ0_FRAC_A  (REQ0_FRAC_A),
        .REQ0_FRAC_B  (REQ0_FRAC_B),
        .REQ1_VALID   (REQ1_VALID),
        .REQ1_READY   (REQ1_READY),
        .REQ1_SCALE_A (REQ1_SCALE_A),
        .REQ1_SCALE_B (REQ1_SCALE_B),
        .REQ1_FRAC_A  (REQ1_FRAC_A),
        .REQ1_FRAC_B  (REQ1_FRAC_B),
        .RES_VALID    (RES_VALID),
        .RES_READY    (RES_READY),
        .RES_ID       (RES_ID),
        .RES_SCALE    (RES_SCALE),
        .RES_FRAC     (RES_FRAC),
        .DONE_CNT     (DONE_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit v;
        int sa;
        int sb;
        int fa;
        int fb;
    } req_t;

    typedef struct {
        bit id;
        int sa;
        int sb;
        int fa;
        int fb;
        bit fresh;
    } op_t;

    req_t     p[2];
    op_t      q[$];
    bit       last_m = 1'b1;
    bit [7:0] done_m = 8'd0;
    int       n_cmp = 0;
    int       n_bad = 0;
    int       n_acc = 0;
    int       offers;
    int       acc0;
    logic [31:0] snap_id, snap_sc, snap_fr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int r, input int sa, input int sb, input int fa, input int fb);
        p[r].v  = 1'b1;
        p[r].sa = sa;
        p[r].sb = sb;
        p[r].fa = fa;
        p[r].fb = fb;
    endtask

    task automatic offer_rand(input int r);
        offer(r, int'($urandom_range(15, 0)) - 8, int'($urandom_range(15, 0)) - 8,
              int'($urandom_range(63, 0)), int'($urandom_range(63, 0)));
    endtask

    task automatic drive();
        REQ0_VALID   = p[0].v;
        REQ0_SCALE_A = 4'(p[0].sa);
        REQ0_SCALE_B = 4'(p[0].sb);
        REQ0_FRAC_A  = 6'(p[0].fa);
        REQ0_FRAC_B  = 6'(p[0].fb);
        REQ1_VALID   = p[1].v;
        REQ1_SCALE_A = 4'(p[1].sa);
        REQ1_SCALE_B = 4'(p[1].sb);
        REQ1_FRAC_A  = 6'(p[1].fa);
        REQ1_FRAC_B  = 6'(p[1].fb);
    endtask

    // One clock: drive at negedge, compare before the rising edge, then advance the model
    task automatic step(input bit rr, input bit rn);
        bit   erv, sp, g0, g1, e0, e1;
        op_t  h, o;
        @(negedge CLK);
        RST_N     = rn;
        RES_READY = rr;
        drive();
        #1;
        if (!rn) begin
            q.delete();
            last_m = 1'b1;
            done_m = 8'd0;
        end
        erv = (q.size() > 0) && !q[0].fresh;
        sp  = rn && ((q.size() < 2) || (erv && rr));
        g0  = p[0].v && (!p[1].v || last_m);
        g1  = p[1].v && (!p[0].v || !last_m);
        e0  = g0 && sp;
        e1  = g1 && sp;
        chk("req0_ready", 32'(REQ0_READY), 32'(e0));
        chk("req1_ready", 32'(REQ1_READY), 32'(e1));
        chk("res_valid", 32'(RES_VALID), 32'(erv));
        chk("done_cnt", 32'(DONE_CNT), 32'(done_m));
        if (!rn) begin
            chk("rst_id", 32'(RES_ID), 32'd0);
            chk("rst_scale", 32'(RES_SCALE), 32'd0);
            chk("rst_frac", 32'(RES_FRAC), 32'd0);
        end
        if (erv) begin
            h = q[0];
            chk("res_id", 32'(RES_ID), 32'(h.id));
            chk("res_scale", 32'(RES_SCALE), 32'((h.sa + h.sb) & 31));
            chk("res_frac", 32'(RES_FRAC), 32'(h.fa * h.fb));
        end
        @(posedge CLK);
        if (rn) begin
            if (erv && rr) begin
                void'(q.pop_front());
                done_m++;
            end
            foreach (q[i]) q[i].fresh = 1'b0;
            if (e0 || e1) begin
                o.id    = e1;
                o.sa    = p[e1].sa;
                o.sb    = p[e1].sb;
                o.fa    = p[e1].fa;
                o.fb    = p[e1].fb;
                o.fresh = 1'b1;
                q.push_back(o);
                last_m  = e1;
                p[e1].v = 1'b0;
                n_acc++;
            end
        end
    endtask

    initial begin
        p[0] = '{0, 0, 0, 0, 0};
        p[1] = '{0, 0, 0, 0, 0};

        // Reset state, with a request already waiting
        offer(0, 1, 1, 1, 1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Single op
        offer(0, 3, -2, 32, 48);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #1;
        chk("single_valid", 32'(RES_VALID), 32'd1);
        chk("single_id", 32'(RES_ID), 32'd0);
        chk("single_scale", 32'(RES_SCALE), 32'd1);
        chk("single_frac", 32'(RES_FRAC), 32'd1536);

        // Extremes
        offer(1, -8, -8, 63, 63);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #1;
        chk("ext_id", 32'(RES_ID), 32'd1);
        chk("ext_scale", 32'(RES_SCALE), 32'h10);
        chk("ext_frac", 32'(RES_FRAC), 32'hF81);
        step(1'b1, 1'b1);

        // Fairness: both continuously valid for six accepted ops
        offer_rand(0);
        offer_rand(1);
        offers = 2;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1);
            for (int r = 0; r < 2; r++) begin
                if (!p[r].v && offers < 6) begin
                    offer_rand(r);
                    offers++;
                end
            end
            if (i > 0) begin
                #1;
                chk("fair_valid", 32'(RES_VALID), 32'd1);
                chk("fair_id", 32'(RES_ID), 32'((i - 1) % 2));
            end
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // Back-pressure
        acc0 = n_acc;
        offer_rand(0);
        offer_rand(1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        #1;
        snap_id = 32'(RES_ID);
        snap_sc = 32'(RES_SCALE);
        snap_fr = 32'(RES_FRAC);
        offer_rand(0);
        offer_rand(1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("bp_accepts", 32'(n_acc - acc0), 32'd2);
        #1;
        chk("bp_hold_valid", 32'(RES_VALID), 32'd1);
        chk("bp_hold_id", 32'(RES_ID), snap_id);
        chk("bp_hold_scale", 32'(RES_SCALE), snap_sc);
        chk("bp_hold_frac", 32'(RES_FRAC), snap_fr);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

        // Reset with both stages full
        offer_rand(0);
        offer_rand(1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        offer_rand(0);
        offer_rand(1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);

        // Random traffic, long enough for DONE_CNT to wrap
        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p[r].v && $urandom_range(3, 0) != 0) offer_rand(r);
            end
            step($urandom_range(3, 0) != 0, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/posit_mul_arbiter.md
# posit_mul_arbiter

Two-requester round-robin arbiter and two-stage pipeline controller that shares a single decoded-posit scale-add / fraction-multiply datapath (`scale_and_mul`, instantiated inside this block) between two independent clients. Each requester hands over decoded operands (scale + fraction) on a valid/ready handshake. The block issues at most one operation per cycle into the datapath and returns the tagged result on a back-pressurable output port. It sits between the posit decoders and the normalise/round/encode stage of the multiplier path.

## Interface
- `SPEED`, 0, passed unchanged to the internal `scale_and_mul` instance.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `REQ0_VALID` in 1: requester 0 holds a valid operation.
- `REQ0_READY` out 1: requester 0 operation accepted this cycle.
- `REQ0_SCALE_A`, `REQ0_SCALE_B` in 4 each: 4-bit signed scales.
- `REQ0_FRAC_A`, `REQ0_FRAC_B` in 6 each: <1.5> unsigned fractions.
- `REQ1_VALID`, `REQ1_READY`, `REQ1_SCALE_A`, `REQ1_SCALE_B`, `REQ1_FRAC_A`, `REQ1_FRAC_B`: identical to requester 0.
- `RES_VALID` out 1: result register holds a valid result.
- `RES_READY` in 1: downstream accepts the result.
- `RES_ID` out 1: index of the requester that issued the result.
- `RES_SCALE` out 5: signed sum of scales.
- `RES_FRAC` out 12: <2.10> unsigned product of fractions.
- `DONE_CNT` out 8: count of completed output handshakes, wraps.

## Operation
- Transfer rule: a handshake completes on an edge where VALID and READY are both 1. A requester holding VALID keeps its operands stable until accepted and never drops VALID before acceptance.
- Stage S1 (issue register) holds valid bit, ID and four operands.
- Stage S2 (result register) drives the `RES_*` outputs from the `scale_and_mul` outputs computed on S1 contents.
- Stall logic:
  - `s2_load = !RES_VALID || RES_READY`
  - `s1_load = !s1_valid || s2_load`
- Grant is combinational from `REQx_VALID` and the pointer `LAST`, which holds the ID of the last accepted requester.
  - One requester valid: it is granted.
  - Both valid: the requester != `LAST` is granted.
  - `REQx_READY = grant_x && s1_load`. READY may depend on VALID; VALID must never depend on READY.
- `LAST` updates only on an accepted request. A stalled grant does not move it.
- On `s1_load`: S1 captures the granted operands and ID, with `s1_valid = 1` if any requester is accepted, else 0.
- On `s2_load`: S2 captures the datapath outputs and the S1 ID, with `RES_VALID = s1_valid`.
- Arithmetic:
  - `RES_SCALE = sext5(SCALE_A) + sext5(SCALE_B)`, range −16..+14, no overflow.
  - `RES_FRAC = FRAC_A * FRAC_B`, full 12-bit, no truncation.
- `DONE_CNT` increments on each `RES_VALID && RES_READY` and wraps from 255 to 0.
- Reset values: `RES_VALID` = 0, `RES_ID` = 0, `RES_SCALE` = 0, `RES_FRAC` = 0, `DONE_CNT` = 0, `s1_valid` = 0, `LAST` = 1 (requester 0 wins the first tie).
- Reset asserted mid-operation discards S1 and S2 contents immediately. No result is produced for in-flight operations.
- The `REQx_READY` outputs are combinational and read 0 while `RST_N` = 0.

## Timing
- Latency: a request accepted at edge N appears on `RES_*` with `RES_VALID` = 1 after edge N+1.
- Throughput is one operation per cycle with `RES_READY` held at 1. With both requesters continuously valid, grants alternate 0,1,0,1…
- Back-pressure with `RES_READY` = 0 and `RES_VALID` = 1:
  - S2 holds its contents and the `RES_*` outputs stay stable.
  - S1 holds if valid; otherwise it still accepts one request.
  - Once S1 is full, both READYs are 0.
- A full pipeline drains one entry per `RES_READY` cycle. A new request is accepted in the same cycle S1 advances (no bubble).
- The datapath between S1 and S2 is purely combinational and must close timing within one cycle.

## Test plan
- Single op: REQ0 drives scales 3 and −2 and fracs 32 and 48, one cycle -> after edge N+1, `RES_VALID` = 1, `RES_ID` = 0, `RES_SCALE` = 5'd1, `RES_FRAC` = 12'd1536.
- Extremes: REQ1 drives scales −8 and −8 and fracs 63 and 63 -> `RES_SCALE` = 5'b10000, `RES_FRAC` = 12'hF81, `RES_ID` = 1.
- Fairness: both VALID continuously for 6 accepted ops with `RES_READY` = 1 -> `RES_ID` sequence 0,1,0,1,0,1 with one result per cycle.
- Back-pressure: `RES_READY` = 0 with both requesters valid -> exactly 2 requests accepted, then both READY = 0 and the `RES_*` outputs stay stable. Release `RES_READY` -> both results emerge in order and `LAST` has not skipped either requester.
- Reset mid-flight: assert `RST_N` = 0 with S1 and S2 full -> `RES_VALID` = 0 and `DONE_CNT` = 0 immediately. After release, the first tie grants requester 0.
- Counter wrap: 256 completed handshakes -> `DONE_CNT` returns to 0. Cycles with `RES_READY` = 0 do not increment it.
